// File: rtl/nanorv32_exwb_stage_pkg.sv
// rtl/nanorv32_exwb_stage_pkg.sv - shared constants for the NANORV32 EX->WB stage
package nanorv32_exwb_stage_pkg;

  localparam logic [1:0] NANORV32_EXWB_SEL_ALU  = 2'd0;
  localparam logic [1:0] NANORV32_EXWB_SEL_LINK = 2'd1;
  localparam logic [1:0] NANORV32_EXWB_SEL_COND = 2'd2;

  typedef enum logic [1:0] {
    NANORV32_EXWB_ST_EMPTY = 2'd0,
    NANORV32_EXWB_ST_ONE   = 2'd1,
    NANORV32_EXWB_ST_TWO   = 2'd2
  } exwb_state_e;

  function automatic logic [31:0] exwb_select(input logic [1:0] sel,
                                              input logic [31:0] alu_res,
                                              input logic [31:0] pc_plus4,
                                              input logic        alu_cond);
    logic [31:0] v;
    v = alu_res;
    case (sel)
      NANORV32_EXWB_SEL_LINK: v = pc_plus4;
      NANORV32_EXWB_SEL_COND: v = {31'd0, alu_cond};
      default:                v = alu_res;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/nanorv32_skid_buf.sv
// rtl/nanorv32_skid_buf.sv - 2-entry valid/ready skid buffer with flush
module nanorv32_skid_buf
  import nanorv32_exwb_stage_pkg::*;
#(
  parameter int W = 38
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [W-1:0] up_tdata,
  input  logic         up_tvalid,
  output logic         up_tready,
  output logic [W-1:0] dn_tdata,
  output logic         dn_tvalid,
  input  logic         dn_tready
);

  exwb_state_e  state, state_nxt;
  logic [W-1:0] main_q, skid_q;
  logic         accept, consume;

  // Flush kills a same-cycle upstream transfer as well as buffered entries.
  assign accept  = up_tvalid && up_tready && !flush;
  assign consume = dn_tvalid && dn_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= NANORV32_EXWB_ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      if (!flush) begin
        case (state)
          NANORV32_EXWB_ST_EMPTY: if (accept) main_q <= up_tdata;
          NANORV32_EXWB_ST_ONE: begin
            if (accept && consume)  main_q <= up_tdata;
            else if (accept)        skid_q <= up_tdata;
          end
          NANORV32_EXWB_ST_TWO:   if (consume) main_q <= skid_q;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = NANORV32_EXWB_ST_EMPTY;
    end else begin
      case (state)
        NANORV32_EXWB_ST_EMPTY:
          if (accept) state_nxt = NANORV32_EXWB_ST_ONE;
        NANORV32_EXWB_ST_ONE:
          if (accept && !consume)      state_nxt = NANORV32_EXWB_ST_TWO;
          else if (!accept && consume) state_nxt = NANORV32_EXWB_ST_EMPTY;
        NANORV32_EXWB_ST_TWO:
          if (consume) state_nxt = NANORV32_EXWB_ST_ONE;
        default: state_nxt = NANORV32_EXWB_ST_EMPTY;
      endcase
    end
  end

  // Handshake outputs decode the state register only, never dn_tready.
  always_comb begin
    up_tready = (state != NANORV32_EXWB_ST_TWO);
    dn_tvalid = (state != NANORV32_EXWB_ST_EMPTY);
    dn_tdata  = main_q;
  end

endmodule

// File: rtl/nanorv32_exwb_stage.sv
// rtl/nanorv32_exwb_stage.sv - NANORV32 EX->WB register stage with redirect
module nanorv32_exwb_stage
  import nanorv32_exwb_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_cond,
  input  logic [1:0]        ex_sel,
  input  logic [DATA_W-1:0] ex_pc_plus4,
  input  logic              ex_br,
  input  logic              ex_jmp,
  input  logic [DATA_W-1:0] ex_target,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic              ex_rd_we,
  input  logic              flush,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_we,
  output logic [DATA_W-1:0] wb_data,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc
);

  localparam int ENT_W = DATA_W + RD_W + 1;

  logic [DATA_W-1:0] sel_data;
  logic [ENT_W-1:0]  ent_in, ent_out;
  logic              accept, taken;

  always_comb begin
    sel_data = alu_res;
    case (ex_sel)
      NANORV32_EXWB_SEL_LINK: sel_data = ex_pc_plus4;
      NANORV32_EXWB_SEL_COND: sel_data = {{(DATA_W-1){1'b0}}, alu_cond};
      default:                sel_data = alu_res;
    endcase
  end

  // x0 write suppression is folded in at capture so wb_we comes straight from a flop.
  assign ent_in = {sel_data, ex_rd, ex_rd_we && (ex_rd != '0)};
  assign accept = ex_valid && ex_ready && !flush;
  assign taken  = accept && (ex_jmp || (ex_br && alu_cond));

  nanorv32_skid_buf #(.W(ENT_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .up_tdata  (ent_in),
    .up_tvalid (ex_valid),
    .up_tready (ex_ready),
    .dn_tdata  (ent_out),
    .dn_tvalid (wb_valid),
    .dn_tready (wb_ready)
  );

  assign wb_data = ent_out[ENT_W-1 -: DATA_W];
  assign wb_rd   = ent_out[RD_W:1];
  assign wb_we   = ent_out[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect <= taken;
      if (taken) redirect_pc <= ex_target;
    end
  end

endmodule

// File: tb/tb_nanorv32_exwb_stage.sv
// tb/tb_nanorv32_exwb_stage.sv - directed self-checking bench for nanorv32_exwb_stage
module tb_nanorv32_exwb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [31:0] alu_res;
  logic        alu_cond;
  logic [1:0]  ex_sel;
  logic [31:0] ex_pc_plus4;
  logic        ex_br, ex_jmp;
  logic [31:0] ex_target;
  logic [4:0]  ex_rd;
  logic        ex_rd_we, flush;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [31:0] wb_data;
  logic        redirect;
  logic [31:0] redirect_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nanorv32_exwb_stage #(.DATA_W(32), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_res(alu_res), .alu_cond(alu_cond), .ex_sel(ex_sel),
    .ex_pc_plus4(ex_pc_plus4), .ex_br(ex_br), .ex_jmp(ex_jmp),
    .ex_target(ex_target), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
    .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_we(wb_we), .wb_data(wb_data),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 0; alu_res = 0; alu_cond = 0; ex_sel = 0; ex_pc_plus4 = 0;
    ex_br = 0; ex_jmp = 0; ex_target = 0; ex_rd = 0; ex_rd_we = 0; flush = 0;
  endtask

  task automatic offer_alu(input logic [31:0] v);
    idle();
    ex_valid = 1; alu_res = v; alu_cond = |v; ex_rd = 5'd3; ex_rd_we = 1;
  endtask

  initial begin
    idle();
    wb_ready = 1;
    rst_n = 0;
    #12;
    check("rst_wb_valid", 32'(wb_valid), 0);
    check("rst_wb_we", 32'(wb_we), 0);
    check("rst_wb_rd", 32'(wb_rd), 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_redirect", 32'(redirect), 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_ex_ready", 32'(ex_ready), 1);
    @(posedge clk); #1 rst_n = 1;

    // streaming, one result per cycle
    for (int i = 0; i < 8; i++) begin
      offer_alu(32'h10 + 32'(i));
      step();
      check("stream_valid", 32'(wb_valid), 1);
      check("stream_data", wb_data, 32'h10 + 32'(i));
      check("stream_ready", 32'(ex_ready), 1);
    end
    check("stream_we", 32'(wb_we), 1);
    idle(); step();
    check("stream_drain", 32'(wb_valid), 0);

    // backpressure
    wb_ready = 0;
    offer_alu(32'hA); step();
    check("bp_a_data", wb_data, 32'hA);
    check("bp_a_ready", 32'(ex_ready), 1);
    offer_alu(32'hB); step();
    check("bp_b_ready", 32'(ex_ready), 0);
    check("bp_b_hold", wb_data, 32'hA);
    offer_alu(32'hC); step();
    check("bp_c_hold", wb_data, 32'hA);
    check("bp_c_ready", 32'(ex_ready), 0);
    wb_ready = 1; step();
    check("bp_rel_b", wb_data, 32'hB);
    check("bp_rel_ready", 32'(ex_ready), 1);
    step();
    check("bp_rel_c", wb_data, 32'hC);
    check("bp_rel_c_valid", 32'(wb_valid), 1);
    idle(); step();
    check("bp_empty", 32'(wb_valid), 0);

    // taken branch
    idle(); ex_valid = 1; ex_br = 1; alu_cond = 1; alu_res = 1; ex_target = 32'h100;
    step();
    check("br_redirect", 32'(redirect), 1);
    check("br_pc", redirect_pc, 32'h100);
    check("br_we", 32'(wb_we), 0);
    idle(); step();
    check("br_pulse_end", 32'(redirect), 0);
    // not-taken branch
    ex_valid = 1; ex_br = 1; alu_cond = 0; ex_target = 32'h200;
    step();
    check("nt_redirect", 32'(redirect), 0);
    check("nt_valid", 32'(wb_valid), 1);
    // jump with link, back-to-back
    idle(); ex_valid = 1; ex_jmp = 1; ex_sel = 2'd1; ex_pc_plus4 = 32'h84;
    ex_rd = 5'd1; ex_rd_we = 1; ex_target = 32'h300; alu_res = 32'h55;
    step();
    check("jal_data", wb_data, 32'h84);
    check("jal_we", 32'(wb_we), 1);
    check("jal_rd", 32'(wb_rd), 1);
    check("jal_redirect", 32'(redirect), 1);
    check("jal_pc", redirect_pc, 32'h300);
    ex_target = 32'h400; step();
    check("jal2_redirect", 32'(redirect), 1);
    check("jal2_pc", redirect_pc, 32'h400);
    idle(); step();
    check("jal_pulse_end", 32'(redirect), 0);

    // cond select zero-extends alu_cond
    ex_valid = 1; ex_sel = 2'd2; alu_res = 32'h5; alu_cond = 1; ex_rd = 5'd7; ex_rd_we = 1;
    step();
    check("cond_data", wb_data, 32'h1);
    ex_sel = 2'd3; alu_res = 32'h77; step();
    check("sel3_data", wb_data, 32'h77);

    // x0 destination
    idle(); ex_valid = 1; alu_res = 32'hDEAD; alu_cond = 1; ex_rd = 0; ex_rd_we = 1;
    step();
    check("x0_valid", 32'(wb_valid), 1);
    check("x0_we", 32'(wb_we), 0);
    check("x0_data", wb_data, 32'hDEAD);
    idle(); step();

    // flush in TWO with a simultaneous taken jump
    wb_ready = 0;
    offer_alu(32'h1); step();
    offer_alu(32'h2); step();
    check("fl_two_ready", 32'(ex_ready), 0);
    idle(); ex_valid = 1; ex_jmp = 1; ex_target = 32'h500; flush = 1;
    step();
    check("fl_valid", 32'(wb_valid), 0);
    check("fl_redirect", 32'(redirect), 0);
    check("fl_ready", 32'(ex_ready), 1);
    // flush in ONE drops an acceptable taken jump
    idle(); offer_alu(32'h3); step();
    idle(); ex_valid = 1; ex_jmp = 1; ex_target = 32'h600; flush = 1;
    step();
    check("fl1_valid", 32'(wb_valid), 0);
    check("fl1_redirect", 32'(redirect), 0);
    idle(); step();
    check("fl1_after", 32'(wb_valid), 0);

    // async reset while in TWO with a redirect pending
    offer_alu(32'h9); step();
    idle(); ex_valid = 1; ex_jmp = 1; ex_target = 32'h700; alu_res = 32'h8; step();
    check("ar_pre_redirect", 32'(redirect), 1);
    check("ar_pre_ready", 32'(ex_ready), 0);
    idle();
    #3 rst_n = 0;
    #1;
    check("ar_valid", 32'(wb_valid), 0);
    check("ar_data", wb_data, 0);
    check("ar_redirect", 32'(redirect), 0);
    check("ar_ready", 32'(ex_ready), 1);
    wb_ready = 1;
    @(posedge clk); #1 rst_n = 1;
    step();
    check("ar_post_redirect", 32'(redirect), 0);
    check("ar_post_valid", 32'(wb_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nanorv32_exwb_stage.md
# nanorv32_exwb_stage

Registered EX→WB pipeline stage of the NANORV32 core, directly downstream of the ALU. It captures `alu_res`/`alu_cond` with the instruction's destination info and selects the write-back value. It resolves branch/jump outcomes into a one-cycle redirect pulse and presents results to the register file over a valid/ready handshake. A 2-entry skid buffer keeps `ex_ready` a pure register output, with full throughput.

## Interface
- `DATA_W`, 32, datapath width (equals NANORV32 data width)
- `RD_W`, 5, register index width
- `clk` in 1 — core clock
- `rst_n` in 1 — asynchronous active-low reset
- `ex_valid` in 1 — EX holds an instruction
- `ex_ready` out 1 — stage can accept; transfer when `ex_valid && ex_ready`
- `alu_res` in DATA_W — ALU result
- `alu_cond` in 1 — ALU condition (`|alu_res`)
- `ex_sel` in 2 — write-back select: 0 ALU, 1 link (`ex_pc_plus4`), 2 cond (zero-extended `alu_cond`), 3 = ALU
- `ex_pc_plus4` in DATA_W — link value
- `ex_br` in 1 — conditional branch (taken iff `alu_cond`)
- `ex_jmp` in 1 — unconditional jump (always taken)
- `ex_target` in DATA_W — branch/jump target
- `ex_rd` in RD_W — destination register
- `ex_rd_we` in 1 — instruction writes `ex_rd`
- `flush` in 1 — kill all buffered entries
- `wb_valid` out 1 — write-back entry presented
- `wb_ready` in 1 — register file consumes entry
- `wb_rd` out RD_W — destination
- `wb_we` out 1 — write enable; forced 0 when `wb_rd == 0`
- `wb_data` out DATA_W — selected result
- `redirect` out 1 — one-cycle pulse: taken branch/jump accepted previous cycle
- `redirect_pc` out DATA_W — target, valid with `redirect`

## Operation
- Entry = {data, rd, we}; data selected from `ex_sel` at acceptance, not later.
- States: EMPTY (no entry), ONE (main reg valid), TWO (main + skid valid).
- EMPTY: accept → ONE.
- ONE: accept & consume → ONE (main replaced); accept & !consume → TWO (new entry to skid); consume only → EMPTY.
- TWO: `ex_ready`=0, no accept; consume → ONE (skid moves to main).
- `ex_ready = (state != TWO)`, registered.
- Order preserved: skid entry is always younger than main.
- Redirect: on acceptance with `ex_jmp || (ex_br && alu_cond)`, next cycle `redirect`=1, `redirect_pc`=`ex_target`. A not-taken branch gives no pulse. Branch entries write only if `ex_rd_we` (link).
- `flush`: next state EMPTY. An EX transfer in the same cycle is dropped, and its redirect is suppressed. A redirect already pending (registered last cycle) still asserts.
- `wb_we` = entry we && rd != 0; `wb_data` is forwarded unchanged for rd=0.

## Timing
- Reset (async, `rst_n`=0): state EMPTY; `wb_valid`=0, `wb_we`=0, `wb_rd`=0, `wb_data`=0, `redirect`=0, `redirect_pc`=0, `ex_ready`=1.
- Latency: accept in cycle N → `wb_valid` in N+1 (EMPTY or ONE-with-consume).
- Throughput: 1 entry/cycle while `wb_ready`=1.
- `wb_*` are stable while `wb_valid && !wb_ready`.
- `redirect` is asserted exactly one cycle per taken accept; back-to-back taken accepts give consecutive pulses.
- Reset mid-operation drops all entries immediately; no redirect after release.
- All outputs are registered; no combinational path from `wb_ready` to `ex_ready`.

## Structure
- Shared parameters file gains `NANORV32_EXWB_SEL_ALU/LINK/COND` (2-bit) and the state encoding `NANORV32_EXWB_ST_EMPTY/ONE/TWO`.
- One sub-module: `nanorv32_skid_buf` (parameterised-width 2-entry valid/ready buffer). The stage wraps it with the select mux, rd/we packing, and redirect register.

## Test plan
- Streaming: 8 ALU ops with `wb_ready`=1 and `alu_res`=0x10..0x17 → `wb_data` 0x10..0x17 on consecutive cycles, 1-cycle latency, `ex_ready` stays 1.
- Backpressure: `wb_ready`=0 and 3 offered entries (0xA,0xB,0xC) → 0xA held, 0xB skidded, `ex_ready`=0, 0xC held upstream. Release → 0xA,0xB,0xC in order with no loss.
- Branch: `ex_br`=1, `alu_cond`=1, target 0x100 → `redirect` 1 cycle at 0x100. With `alu_cond`=0 → no pulse. `ex_jmp`, `ex_sel`=1, pc+4=0x84, rd=1 → `wb_data`=0x84, `wb_we`=1, plus redirect.
- x0: rd=0, `ex_rd_we`=1, result 0xDEAD → `wb_valid`=1, `wb_we`=0.
- Flush: state TWO plus `flush` with a simultaneous taken jump → EMPTY next cycle, `wb_valid`=0, no redirect, `ex_ready`=1.
- Async reset asserted in TWO between clock edges → outputs 0 immediately, `ex_ready`=1.
